// File: rtl/paddle_ctl.sv
// Paddle Y controller: 2-flop sync + debounce per button, direction FSM, tick-paced movement with speed ramp and clamping.
// Latency: raw button to moving = 2 + DEBOUNCE_CYCLES + 1 cycles; position changes only on movement ticks.
// Backpressure: none, free-running with registered outputs; optional AI steering is enabled by `PADDLE_AI_EN.
module paddle_ctl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int STEP_DIV        = 200000,
    parameter int ACCEL_TICKS     = 32,
    parameter int SPEED_MAX       = 4,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 668,
    parameter int Y_RESET         = 334
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
`ifdef PADDLE_AI_EN
    input  logic        ai_mode,
    input  logic [10:0] ball_ypos,
`endif
    output logic [10:0] rect_y_pos,
    output logic        moving,
    output logic [2:0]  speed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int AW  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    localparam logic [DBW-1:0]     DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]      TICK_LAST = TW'(STEP_DIV - 1);
    localparam logic [AW-1:0]      ACC_LAST  = AW'(ACCEL_TICKS - 1);
    localparam logic [2:0]         SPD_MAX   = 3'(SPEED_MAX);
    localparam logic signed [11:0] Y_MIN_S   = 12'(Y_MIN);
    localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
    localparam logic [10:0]        Y_MIN_V   = 11'(Y_MIN);
    localparam logic [10:0]        Y_MAX_V   = 11'(Y_MAX);
    localparam logic [10:0]        Y_RESET_V = 11'(Y_RESET);

    logic [1:0]         up_sync;
    logic [1:0]         dn_sync;
    logic [DBW-1:0]     up_cnt;
    logic [DBW-1:0]     dn_cnt;
    logic               du;
    logic               dd;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    state_t             state;
    state_t             state_nxt;
    logic               moving_nxt;
    logic               fsm_up;
    logic               fsm_dn;
    logic               ai_on;
    logic [AW-1:0]      accel_cnt;
    logic [2:0]         step;
    logic signed [11:0] pos_s;
    logic signed [11:0] sum_s;
    logic [10:0]        pos_moved;
    logic               in_motion;

`ifdef PADDLE_AI_EN
    assign ai_on = ai_mode;
`else
    assign ai_on = 1'b0;
`endif

    // Bring the raw asynchronous buttons into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            up_sync <= '0;
            dn_sync <= '0;
        end else begin
            up_sync <= {up_sync[0], btn_up};
            dn_sync <= {dn_sync[0], btn_down};
        end
    end

    // Up-button debounce: accept a change only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            up_cnt <= '0;
            du     <= 1'b0;
        end else if (up_sync[1] == du) begin
            up_cnt <= '0;
        end else if (up_cnt == DB_LAST) begin
            up_cnt <= '0;
            du     <= up_sync[1];
        end else begin
            up_cnt <= up_cnt + DBW'(1);
        end
    end

    // Down-button debounce, same rule as the up button
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_cnt <= '0;
            dd     <= 1'b0;
        end else if (dn_sync[1] == dd) begin
            dn_cnt <= '0;
        end else if (dn_cnt == DB_LAST) begin
            dn_cnt <= '0;
            dd     <= dn_sync[1];
        end else begin
            dn_cnt <= dn_cnt + DBW'(1);
        end
    end

    // Free-running movement tick divider; never paused, even when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Select the FSM's direction request: debounced buttons, or ball tracking in AI mode
    always_comb begin
        fsm_up = du;
        fsm_dn = dd;
`ifdef PADDLE_AI_EN
        if (ai_mode) begin
            fsm_up = (({1'b0, ball_ypos} + 12'd8) < ({1'b0, rect_y_pos} + 12'd50));
            fsm_dn = ({1'b0, ball_ypos} > ({1'b0, rect_y_pos} + 12'd58));
        end
`endif
    end

    // Next direction state and registered moving flag
    always_comb begin
        state_nxt  = IDLE;
        moving_nxt = 1'b0;
        case ({fsm_up, fsm_dn})
            2'b10:   state_nxt = UP;
            2'b01:   state_nxt = DOWN;
            2'b11:   state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
        moving_nxt = (state_nxt == UP) || (state_nxt == DOWN);
    end

    // Direction state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            moving <= 1'b0;
        end else begin
            state  <= state_nxt;
            moving <= moving_nxt;
        end
    end

    assign in_motion = (state == UP) || (state == DOWN);
    assign step      = ai_on ? 3'd2 : speed;

    // Candidate position for this tick, computed signed so it can never wrap past either limit
    always_comb begin
        pos_s     = signed'({1'b0, rect_y_pos});
        sum_s     = pos_s;
        pos_moved = rect_y_pos;
        if (state == UP) begin
            sum_s     = pos_s - signed'({9'd0, step});
            pos_moved = (sum_s < Y_MIN_S) ? Y_MIN_V : sum_s[10:0];
        end else if (state == DOWN) begin
            sum_s     = pos_s + signed'({9'd0, step});
            pos_moved = (sum_s > Y_MAX_S) ? Y_MAX_V : sum_s[10:0];
        end
    end

    // Position update and speed ramp; a tick moves with the speed held before that tick
    always_ff @(posedge clk) begin
        if (rst) begin
            rect_y_pos <= Y_RESET_V;
            speed      <= 3'd1;
            accel_cnt  <= '0;
        end else begin
            if (tick && in_motion) begin
                rect_y_pos <= pos_moved;
            end
            if (ai_on) begin
                speed     <= 3'd2;
                accel_cnt <= '0;
            end else if ((state_nxt != state) || !in_motion) begin
                speed     <= 3'd1;
                accel_cnt <= '0;
            end else if (tick) begin
                if (accel_cnt == ACC_LAST) begin
                    accel_cnt <= '0;
                    if (speed < SPD_MAX) begin
                        speed <= speed + 3'd1;
                    end
                end else begin
                    accel_cnt <= accel_cnt + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctl.sv
// Testbench for paddle_ctl with small timing parameters.
// Directed vector table for the multi-cycle corner cases, then random button activity vs a reference model.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_paddle_ctl;

    localparam int DB   = 4;
    localparam int SD   = 8;
    localparam int AT   = 2;
    localparam int SMAX = 4;
    localparam int YMIN = 0;
    localparam int YMAX = 668;
    localparam int YRST = 334;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up;
    logic        btn_down;
    logic [10:0] rect_y_pos;
    logic        moving;
    logic [2:0]  speed;
`ifdef PADDLE_AI_EN
    logic        ai_mode = 1'b0;
    logic [10:0] ball_ypos = 11'd0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    paddle_ctl #(
        .DEBOUNCE_CYCLES(DB),
        .STEP_DIV       (SD),
        .ACCEL_TICKS    (AT),
        .SPEED_MAX      (SMAX),
        .Y_MIN          (YMIN),
        .Y_MAX          (YMAX),
        .Y_RESET        (YRST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
`ifdef PADDLE_AI_EN
        .ai_mode   (ai_mode),
        .ball_ypos (ball_ypos),
`endif
        .rect_y_pos(rect_y_pos),
        .moving    (moving),
        .speed     (speed)
    );

    // ---------------- reference model ----------------
    // Buttons are delayed two samples, accepted after DB consecutive disagreeing
    // samples; speed is derived from the number of ticks spent in the current run.
    bit up_hist[$];
    bit dn_hist[$];
    bit m_du, m_dd;
    int m_cnt_u, m_cnt_d;
    int m_phase;
    int m_dir;       // 0 idle, 1 up, 2 down, 3 hold
    int m_run;       // ticks spent moving in the current direction run
    int m_y;
    bit su, sd, is_tick;
    int nd, sp;

    function automatic int run_speed(input int run);
        int s;
        s = 1 + run / AT;
        return (s > SMAX) ? SMAX : s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            up_hist = {1'b0, 1'b0};
            dn_hist = {1'b0, 1'b0};
            m_du = 0; m_dd = 0; m_cnt_u = 0; m_cnt_d = 0;
            m_phase = 0; m_dir = 0; m_run = 0; m_y = YRST;
        end else begin
            su = up_hist[0];
            sd = dn_hist[0];
            void'(up_hist.pop_front());
            void'(dn_hist.pop_front());
            up_hist.push_back(btn_up);
            dn_hist.push_back(btn_down);
            nd = m_du ? (m_dd ? 3 : 1) : (m_dd ? 2 : 0);
            if (su != m_du) begin
                m_cnt_u++;
                if (m_cnt_u == DB) begin m_du = su; m_cnt_u = 0; end
            end else m_cnt_u = 0;
            if (sd != m_dd) begin
                m_cnt_d++;
                if (m_cnt_d == DB) begin m_dd = sd; m_cnt_d = 0; end
            end else m_cnt_d = 0;
            is_tick = (m_phase == SD - 1);
            m_phase = (m_phase + 1) % SD;
            if (is_tick && (m_dir == 1 || m_dir == 2)) begin
                sp = run_speed(m_run);
                if (m_dir == 1) m_y = (m_y - sp < YMIN) ? YMIN : m_y - sp;
                else            m_y = (m_y + sp > YMAX) ? YMAX : m_y + sp;
                m_run++;
            end
            if (nd != m_dir) m_run = 0;
            m_dir = nd;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit    r;
        bit    u;
        bit    d;
        int    n;
        int    y;
        int    mov;
        int    spd;
        string name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit u, input bit d, input int n,
                       input int y, input int mov, input int spd, input string name);
        vec_t v;
        v.r = r; v.u = u; v.d = d; v.n = n;
        v.y = y; v.mov = mov; v.spd = spd; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        rst = v.r; btn_up = v.u; btn_down = v.d;
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        chk({v.name, "_y"},     32'(rect_y_pos), 32'(v.y));
        chk({v.name, "_mov"},   32'(moving),     32'(v.mov));
        chk({v.name, "_speed"}, 32'(speed),      32'(v.spd));
    endtask

    int cyc;
    int len;
    bit r_r, r_u, r_d;

    initial begin
        //   rst up dn  cycles  y    mov spd
        add(1, 1, 0,   3,   334, 0, 1, "reset_btn_held");
        add(0, 0, 0,  10,   334, 0, 1, "idle_after_reset");
        add(0, 1, 0,   3,   334, 0, 1, "glitch_active");
        add(0, 0, 0,  10,   334, 0, 1, "glitch_rejected");
        add(0, 1, 0,   6,   334, 0, 1, "debounce_pending");
        add(0, 1, 0,   1,   334, 1, 1, "debounce_accept");
        add(0, 1, 0,   2,   333, 1, 1, "first_up_tick");
        add(0, 1, 0,   8,   332, 1, 2, "second_up_tick");
        add(0, 0, 0,   7,   332, 0, 1, "release_idle");
        add(1, 0, 0,   2,   334, 0, 1, "reset_b");
        add(0, 0, 1,  16,   336, 1, 2, "ramp_2_ticks");
        add(0, 0, 1,  32,   346, 1, 4, "ramp_6_ticks");
        add(0, 0, 1,  48,   370, 1, 4, "ramp_12_ticks");
        add(0, 0, 1, 592,   666, 1, 4, "down_near_max");
        add(0, 0, 1,   8,   668, 1, 4, "down_clamp");
        add(0, 0, 1,  16,   668, 1, 4, "down_stay_max");
        add(1, 0, 0,   2,   334, 0, 1, "reset_c");
        add(0, 1, 0, 688,     2, 1, 4, "up_near_min");
        add(0, 1, 0,   8,     0, 1, 4, "up_clamp");
        add(0, 1, 0,  16,     0, 1, 4, "up_stay_min");
        add(1, 0, 0,   2,   334, 0, 1, "reset_d");
        add(0, 1, 1,   7,   334, 0, 1, "hold_enter");
        add(0, 1, 1,  40,   334, 0, 1, "hold_frozen");
        add(0, 1, 0,   7,   334, 1, 1, "hold_to_up");
        add(0, 1, 0,   2,   333, 1, 1, "hold_to_up_tick");
        add(1, 0, 0,   2,   334, 0, 1, "reset_e");
        add(0, 0, 1,  36,   340, 1, 3, "down_speed3");
        add(1, 0, 1,   1,   334, 0, 1, "reset_mid_move");

        foreach (tbl[i]) run_vec(tbl[i]);

        // Random button activity against the reference model
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (cyc < 20000) begin
            r_r = ($urandom_range(0, 39) == 0);
            r_u = 1'($urandom_range(0, 1));
            r_d = 1'($urandom_range(0, 1));
            if (r_r) len = 1;
            else if ($urandom_range(0, 1) == 0) len = $urandom_range(1, 6);
            else len = $urandom_range(8, 1200);
            rst = r_r; btn_up = r_u; btn_down = r_d;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                cyc++;
                chk("rand_y",     32'(rect_y_pos), 32'(m_y));
                chk("rand_mov",   32'(moving),     32'((m_dir == 1 || m_dir == 2) ? 1 : 0));
                chk("rand_speed", 32'(speed),      32'(run_speed(m_run)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
